instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch-side initiator for the combinational instruction memory. It owns the program counter, drives the fetch address, and captures each returned word with its PC into a small queue. It presents instructions to decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue. Fetching halts on an all-zero word until the next redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `QUEUE_DEPTH`, default 2: fetch queue entries; power of two, 2..8.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `imem_address`  out  32: fetch byte address to the instruction memory; equals the `fetch_pc` register.
- `imem_instruction`  in  32: word returned combinationally for `imem_address` in the same cycle.
- `redirect_valid`  in  1: execute requests a PC change this cycle.
- `redirect_target`  in  32: new fetch byte address; bits [1:0] ignored and treated as 0.
- `inst_valid`  out  1: queue head holds an instruction.
- `inst_ready`  in  1: decode accepts the head this cycle.
- `inst_data`  out  32: head instruction word.
- `inst_pc`  out  32: byte address of the head instruction.
- `halted`  out  1: fetch stopped on a zero word.

## Operation
- States:
  - BOOT: one cycle after reset release; no fetch.
  - RUN: fetching.
  - HALT: entered when a zero word is fetched.
- Transitions:
  - BOOT to RUN unconditionally.
  - RUN to HALT when `imem_instruction == 0` on a fetch cycle.
  - HALT to RUN on `redirect_valid`.
  - `redirect_valid` in BOOT is honoured: PC is loaded and the state goes to RUN.
- Fetch cycle: state RUN, no redirect, and the queue has space (`count < QUEUE_DEPTH`, or a pop happens this same cycle).
  - On a fetch cycle, push {`imem_instruction`, `fetch_pc`} and set `fetch_pc <= fetch_pc + 4`.
  - The PC add wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
- Zero word: it is not pushed, `fetch_pc` holds that address, and `halted` is 1 while in HALT.
  - Instructions already queued still drain normally.
- Pop: `inst_valid && inst_ready`.
- Redirect (highest priority):
  - Flush the queue; the count goes to 0 and any same-cycle push or pop is discarded.
  - Set `fetch_pc <= {redirect_target[31:2], 2'b00}` and the state to RUN.
- Full queue with no pop: no fetch. `fetch_pc` and `imem_address` are held.
- `inst_data`/`inst_pc` are driven from the queue head register. When empty they show the last head value and are don't-care; the bench must not check them while `inst_valid` is 0.
- Reset, also when asserted mid-operation:
  - State returns to BOOT.
  - `fetch_pc` and `imem_address` = `RESET_PC`.
  - Queue emptied.
  - Outputs: `inst_valid` 0, `inst_data` 0, `inst_pc` 0, `halted` 0.

## Timing
- Edge 1 after reset release: BOOT to RUN.
- Edge 2: first push; `inst_valid` is 1 after edge 2.
- Latency from `fetch_pc` to `inst_valid`: 1 edge.
- Throughput: 1 instruction per cycle while `inst_ready` is held at 1.
- Redirect at edge N:
  - `inst_valid` is 0 after edge N.
  - The target is fetched in cycle N+1.
  - The target is valid at the head after edge N+1.
- `halted` rises on the same edge that would have pushed the zero word. It falls on the redirect edge.
- `imem_address` is a registered output with no combinational path from any input.

## Structure
- Shared package/header `fetch_defs`:
  - State encodings: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - `INSTR_WIDTH` = 32.
  - `PC_STEP` = 4.
  - `NOP_HALT_WORD` = 32'h0.
- One sub-module, `fetch_queue`: synchronous FIFO of {instr, pc} entries.
  - Ports: push, pop, flush, full, empty, head.
  - Priority: flush over push and pop.
  - Simultaneous push and pop when full is legal.
- The top level holds the FSM, `fetch_pc`, and the push/pop/redirect arbitration.

## Test plan
- Bench memory word 0 = 32'h00100533, `inst_ready` held 1 → after edge 2, `inst_pc` = 0 and `inst_data` = 32'h00100533; then `inst_pc` = 4, 8, 12 on consecutive cycles.
- `inst_ready` = 0 from reset → queue fills with PCs 0 and 4; `imem_address` holds 8 while full. Raise `inst_ready` → head goes 0, 4, 8 with no bubble.
- `redirect_valid` with target 32'h0000_0026 while the queue holds 2 entries → `inst_valid` = 0 next cycle, then `inst_pc` = 32'h24; no stale PC is delivered.
- Memory word at 32'h2C = 0, free-running from 0 → PCs 0..32'h28 delivered, then `halted` = 1 and `imem_address` holds 32'h2C. Redirect to 0 → `halted` = 0 and PC 0 is re-delivered.
- `RESET_PC` = 32'hFFFF_FFF8 → PCs delivered in order FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `reset` mid-stream with 2 entries queued → `inst_valid`, `halted`, `inst_pc` and `inst_data` are all 0 immediately (asynchronous); `imem_address` = `RESET_PC`; the BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_defs_pkg.sv
// Shared fetch-side definitions: FSM encoding, word constants and queue entry layout.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int                   INSTR_WIDTH   = 32;
  localparam logic [31:0]          PC_STEP       = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] NOP_HALT_WORD = '0;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {instr, pc} entries; flush beats push and pop.
module fetch_queue
  import fetch_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [AW:0]     cnt_q;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Push into a full queue is only issued alongside a pop, so wr_q may equal rd_q here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= entry_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the fetch PC and BOOT/RUN/HALT FSM; arbitrates redirect, push and pop into the fetch queue.
module instruction_fetch_unit
  import fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [31:0]            imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INSTR_WIDTH-1:0] inst_data,
  output logic [31:0]            inst_pc,
  output logic                   halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         q_full, q_empty, pop, fetch, zero_word, push;
  fetch_entry_t q_head, q_entry;

  assign inst_valid   = !q_empty;
  assign pop          = inst_valid && inst_ready;
  assign zero_word    = (imem_instruction == NOP_HALT_WORD);
  assign fetch        = (state_q == ST_RUN) && !redirect_valid && (!q_full || pop);
  assign push         = fetch && !zero_word;
  assign imem_address = fetch_pc_q;
  assign halted       = (state_q == ST_HALT);
  assign inst_data    = q_head.instr;
  assign inst_pc      = q_head.pc;
  assign q_entry      = '{instr: imem_instruction, pc: fetch_pc_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = {redirect_target[31:2], 2'b00};
    end else begin
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          // A zero word parks the PC on its own address until the next redirect.
          if (fetch && zero_word) state_d = ST_HALT;
          if (push)               fetch_pc_d = fetch_pc_q + PC_STEP;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop && !redirect_valid),
    .flush_i (redirect_valid),
    .entry_i (q_entry),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus random stimulus against a queue-based reference model of the fetch unit.
module tb_instruction_fetch_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect_valid, inst_ready, inst_valid, halted;
  logic [31:0] redirect_target, imem_address, imem_instruction, inst_data, inst_pc;
  logic        rv2, rdy2, inst_valid2, halted2;
  logic [31:0] tgt2, imem_address2, imem_instruction2, inst_data2, inst_pc2;
  logic [31:0] zero_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq[$];
  logic [31:0] mpc;
  bit          mboot, mhalt;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] z);
    if (a == z) return 32'h0;
    if (a == 32'h0) return 32'h0010_0533;
    return 32'h13 | (a << 8);
  endfunction

  always_comb imem_instruction  = mem_word(imem_address, zero_addr);
  always_comb imem_instruction2 = mem_word(imem_address2, zero_addr);

  instruction_fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(D)) dut2 (
    .clk(clk), .reset(reset), .imem_address(imem_address2), .imem_instruction(imem_instruction2),
    .redirect_valid(rv2), .redirect_target(tgt2), .inst_valid(inst_valid2),
    .inst_ready(rdy2), .inst_data(inst_data2), .inst_pc(inst_pc2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("inst_pc", inst_pc, mq[0][31:0]);
      chk("inst_data", inst_data, mq[0][63:32]);
    end
    chk("imem_address", imem_address, mpc);
    chk("halted", 32'(halted), 32'(mhalt));
  endtask

  // One clock of spec-level behaviour, evaluated on the pre-edge inputs.
  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] tgt);
    bit          pop, space;
    logic [31:0] w;
    pop = (mq.size() != 0) && rdy;
    if (rv) begin
      mq.delete();
      mpc   = {tgt[31:2], 2'b00};
      mboot = 0;
      mhalt = 0;
    end else if (mboot) begin
      mboot = 0;
    end else begin
      space = (mq.size() < D) || pop;
      w     = mem_word(mpc, zero_addr);
      if (pop) void'(mq.pop_front());
      if (!mhalt && space) begin
        if (w == 32'h0) mhalt = 1;
        else begin
          mq.push_back({w, mpc});
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    inst_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    model_step(rdy, rv, tgt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    inst_ready     = 0;
    redirect_valid = 0;
    reset          = 1;
    mq.delete();
    mpc   = 32'h0;
    mboot = 1;
    mhalt = 0;
    #1;
    check_all();
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_imem2", imem_address2, 32'hFFFF_FFF8);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; inst_ready = 0; redirect_valid = 0; redirect_target = 0;
    rv2 = 0; rdy2 = 1; tgt2 = 0;
    zero_addr = 32'hFFFF_FFF0;

    // Basic stream, plus wrap-around on the second instance
    do_reset();
    cycle(1, 0, 0);
    chk("boot_no_valid", 32'(inst_valid), 32'h0);
    cycle(1, 0, 0);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_data", inst_data, 32'h0010_0533);
    chk("wrap_pc0", inst_pc2, 32'hFFFF_FFF8);
    cycle(1, 0, 0);
    chk("stream_pc4", inst_pc, 32'h4);
    chk("wrap_pc1", inst_pc2, 32'hFFFF_FFFC);
    cycle(1, 0, 0);
    chk("stream_pc8", inst_pc, 32'h8);
    chk("wrap_pc2", inst_pc2, 32'h0);
    cycle(1, 0, 0);
    chk("stream_pc12", inst_pc, 32'hC);

    // Backpressure: fill, hold PC, then drain with no bubble
    do_reset();
    repeat (4) cycle(0, 0, 0);
    chk("full_hold_addr", imem_address, 32'h8);
    chk("full_head", inst_pc, 32'h0);
    cycle(1, 0, 0);
    chk("drain_pc4", inst_pc, 32'h4);
    cycle(1, 0, 0);
    chk("drain_pc8", inst_pc, 32'h8);

    // Redirect flushes a full queue
    repeat (2) cycle(0, 0, 0);
    cycle(0, 1, 32'h26);
    chk("redir_flush", 32'(inst_valid), 32'h0);
    cycle(1, 0, 0);
    chk("redir_target", inst_pc, 32'h24);

    // Halt on zero word, resume on redirect
    zero_addr = 32'h2C;
    do_reset();
    repeat (14) cycle(1, 0, 0);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_addr", imem_address, 32'h2C);
    cycle(1, 1, 32'h0);
    chk("unhalt", 32'(halted), 32'h0);
    cycle(1, 0, 0);
    chk("refetch_pc0", inst_pc, 32'h0);

    // Asynchronous reset mid-stream with two entries queued
    do_reset();
    repeat (3) cycle(0, 0, 0);
    chk("pre_rst_full", 32'(inst_valid), 32'h1);
    #2;
    do_reset();
    repeat (4) cycle(1, 0, 0);

    // Random traffic
    zero_addr = 32'h30;
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom_range(0, 63));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
